// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

  parameter int unsigned DefaultDataW = 32;
  parameter int unsigned DefaultAddrW = 2;
  parameter int unsigned ZeroIdx      = 0;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback and issue signals of the scoreboarded register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) ();

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegNo;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              ReadBusy1;
  logic              ReadBusy2;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueRegNo;
  logic              IssueReady;
  logic [ADDR_W:0]   BusyCount;

  modport slave (
    input  RegWrite, WriteRegNo, WriteData, ReadReg1, ReadReg2, IssueValid, IssueRegNo,
    output ReadData1, ReadData2, ReadBusy1, ReadBusy2, IssueReady, BusyCount
  );

  modport master (
    output RegWrite, WriteRegNo, WriteData, ReadReg1, ReadReg2, IssueValid, IssueRegNo,
    input  ReadData1, ReadData2, ReadBusy1, ReadBusy2, IssueReady, BusyCount
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue reserves a destination, writeback releases it.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned Depth   = depth_of(ADDR_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] write_reg_no_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_reg_no_i,
  output logic              issue_ready_o,
  output logic [Depth-1:0]  busy_o,
  output logic [ADDR_W:0]   busy_count_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  logic [Depth-1:0] busy_q, busy_d;
  logic             issue_is_zero;
  logic             issue_fire;

  assign issue_is_zero = ZERO_REG && (issue_reg_no_i == ADDR_W'(ZeroIdx));

  // A same-cycle writeback to the reserved register releases it in time for re-issue.
  assign issue_ready_o = ~busy_q[issue_reg_no_i] |
                         (reg_write_i && (write_reg_no_i == issue_reg_no_i));
  assign issue_fire    = issue_valid_i && issue_ready_o && !issue_is_zero;

  // Set is applied after clear so a same-edge issue keeps the register reserved.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_i) busy_d[write_reg_no_i] = 1'b0;
    if (issue_fire)  busy_d[issue_reg_no_i] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    busy_count_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      busy_count_o = busy_count_o + CntW'(busy_q[i]);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two bypassed combinational read ports, one write port and a busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter bit          ZERO_REG = 1'b0
) (
  input logic        clock,
  input logic        reset,
  regfile_sb_if.slave bus
);

  localparam int unsigned Depth = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy;
  logic              mem_we;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .reg_write_i    (bus.RegWrite),
    .write_reg_no_i (bus.WriteRegNo),
    .issue_valid_i  (bus.IssueValid),
    .issue_reg_no_i (bus.IssueRegNo),
    .issue_ready_o  (bus.IssueReady),
    .busy_o         (busy),
    .busy_count_o   (bus.BusyCount)
  );

  assign mem_we = bus.RegWrite && !(ZERO_REG && (bus.WriteRegNo == ADDR_W'(ZeroIdx)));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[bus.WriteRegNo] <= bus.WriteData;
    end
  end

  // Zero-register override comes last so it also masks the bypass path.
  always_comb begin
    bus.ReadData1 = mem_q[bus.ReadReg1];
    bus.ReadBusy1 = busy[bus.ReadReg1];
    if (bus.RegWrite && (bus.WriteRegNo == bus.ReadReg1)) begin
      bus.ReadData1 = bus.WriteData;
      bus.ReadBusy1 = 1'b0;
    end
    if (ZERO_REG && (bus.ReadReg1 == ADDR_W'(ZeroIdx))) begin
      bus.ReadData1 = '0;
      bus.ReadBusy1 = 1'b0;
    end
  end

  always_comb begin
    bus.ReadData2 = mem_q[bus.ReadReg2];
    bus.ReadBusy2 = busy[bus.ReadReg2];
    if (bus.RegWrite && (bus.WriteRegNo == bus.ReadReg2)) begin
      bus.ReadData2 = bus.WriteData;
      bus.ReadBusy2 = 1'b0;
    end
    if (ZERO_REG && (bus.ReadReg2 == ADDR_W'(ZeroIdx))) begin
      bus.ReadData2 = '0;
      bus.ReadBusy2 = 1'b0;
    end
  end

endmodule
